// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and line helpers for the line-wide data memory.
package dmem_pkg;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int CTR_W          = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input int unsigned        idx);
    return line[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dmem_latency_ctr.sv
// Loadable 6-bit down-counter with a zero flag; holds at zero rather than wrapping.
module dmem_latency_ctr
  import dmem_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic [CTR_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dmem_line_ctrl.sv
// Fixed-latency 128-bit line store behind the data cache with BUSY/DONE/COLLIDE status.
// Optional per-word write mask when DMEM_WORD_MASK_EN is defined.
module dmem_line_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 6
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      D_MEM_CSN,
  input  logic                      D_MEM_WEN,
  input  logic [ADDR_W-1:0]         D_MEM_ADDR,
  input  logic [LINE_W-1:0]         D_MEM_WDATA,
`ifdef DMEM_WORD_MASK_EN
  input  logic [WORDS_PER_LINE-1:0] D_MEM_WMASK,
`endif
  output logic [LINE_W-1:0]         D_MEM_RDATA,
  output logic                      D_MEM_BUSY,
  output logic                      D_MEM_DONE,
  output logic                      D_MEM_COLLIDE,
  output logic [0:0]                dbg_state,
  output logic [CTR_W-1:0]          dbg_count
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_WAIT = WAIT;
  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a request is accepted on a rising edge with D_MEM_CSN=0 while idle;
  // D_MEM_BUSY stays high until the completion edge, after which D_MEM_DONE pulses
  // for one cycle. Strobes seen while busy are dropped and flagged on D_MEM_COLLIDE.

  logic [0:0]                state_q;
  logic                      wen_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [LINE_W-1:0]         wdata_q;
  logic [WORDS_PER_LINE-1:0] wmask_q;

  logic [LINE_W-1:0]         mem [DEPTH];

  logic                      start;
  logic                      finish;
  logic                      ctr_zero;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;

  assign start    = (state_q == ST_IDLE) && !D_MEM_CSN;
  assign finish   = (state_q == ST_WAIT) && ctr_zero;
  assign in_range = (32'(addr_q) < DEPTH);
  assign idx      = addr_q[IDX_W-1:0];

  dmem_latency_ctr u_ctr (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .load     (start),
    .load_val (CTR_W'(LATENCY - 1)),
    .dec      (state_q == ST_WAIT),
    .count    (dbg_count),
    .zero     (ctr_zero)
  );

  // Request capture: later changes on the bus cannot affect the op in flight.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wen_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (start) begin
      wen_q   <= D_MEM_WEN;
      addr_q  <= D_MEM_ADDR;
      wdata_q <= D_MEM_WDATA;
`ifdef DMEM_WORD_MASK_EN
      wmask_q <= D_MEM_WMASK;
`else
      wmask_q <= '1;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= ST_IDLE;
      D_MEM_BUSY    <= 1'b0;
      D_MEM_DONE    <= 1'b0;
      D_MEM_COLLIDE <= 1'b0;
      D_MEM_RDATA   <= '0;
    end else begin
      D_MEM_DONE <= finish;
      if (start) begin
        state_q    <= ST_WAIT;
        D_MEM_BUSY <= 1'b1;
      end else if (finish) begin
        state_q    <= ST_IDLE;
        D_MEM_BUSY <= 1'b0;
      end
      if ((state_q == ST_WAIT) && !D_MEM_CSN) begin
        D_MEM_COLLIDE <= 1'b1;
      end
      if (finish && wen_q) begin
        D_MEM_RDATA <= in_range ? mem[idx] : '0;
      end
    end
  end

  // Array is deliberately unreset; an abandoned op never reaches finish.
  always_ff @(posedge CLK) begin
    if (finish && !wen_q && in_range) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        if (wmask_q[w]) begin
          mem[idx][w*WORD_W +: WORD_W] <= line_word(wdata_q, w);
        end
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Directed plus randomized checks of dmem_line_ctrl against a line-level reference model.
module tb_dmem_line_ctrl;
  import dmem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 512;
  localparam int LAT    = 6;
  localparam int LAT1   = 1;

  // clock / reset
  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic              csn   = 1'b1;
  logic              wen   = 1'b1;
  logic [ADDR_W-1:0] addr  = '0;
  logic [127:0]      wdata = '0;
  logic [127:0]      rdata;
  logic              busy, done, collide;
  logic [0:0]        state;
  logic [5:0]        count;

  logic              csn1   = 1'b1;
  logic              wen1   = 1'b1;
  logic [ADDR_W-1:0] addr1  = '0;
  logic [127:0]      wdata1 = '0;
  logic [127:0]      rdata1;
  logic              busy1, done1, collide1;
  logic [0:0]        state1;
  logic [5:0]        count1;

`ifdef DMEM_WORD_MASK_EN
  logic [3:0] wmask  = 4'hF;
  logic [3:0] wmask1 = 4'hF;
`endif

  dmem_line_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RSTn(RSTn), .D_MEM_CSN(csn), .D_MEM_WEN(wen), .D_MEM_ADDR(addr),
    .D_MEM_WDATA(wdata),
`ifdef DMEM_WORD_MASK_EN
    .D_MEM_WMASK(wmask),
`endif
    .D_MEM_RDATA(rdata), .D_MEM_BUSY(busy), .D_MEM_DONE(done), .D_MEM_COLLIDE(collide),
    .dbg_state(state), .dbg_count(count)
  );

  dmem_line_ctrl #(.ADDR_W(ADDR_W), .DEPTH(1024), .LATENCY(LAT1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .D_MEM_CSN(csn1), .D_MEM_WEN(wen1), .D_MEM_ADDR(addr1),
    .D_MEM_WDATA(wdata1),
`ifdef DMEM_WORD_MASK_EN
    .D_MEM_WMASK(wmask1),
`endif
    .D_MEM_RDATA(rdata1), .D_MEM_BUSY(busy1), .D_MEM_DONE(done1), .D_MEM_COLLIDE(collide1),
    .dbg_state(state1), .dbg_count(count1)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard and reference model
  logic [127:0] exp_q[$];
  logic [127:0] model_mem [int];
  logic [127:0] last_rd = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_read(input int a);
    if (a >= DEPTH) return '0;
    if (model_mem.exists(a)) return model_mem[a];
    return '0;
  endfunction

  task automatic model_write(input int a, input logic [127:0] d, input logic [3:0] m);
    logic [127:0] line;
    if (a >= DEPTH) return;
    line = model_read(a);
    for (int w = 0; w < 4; w++) begin
      if (m[w]) line[w*32 +: 32] = d[w*32 +: 32];
    end
    model_mem[a] = line;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input logic w, input int exp_edges);
    int n = 0;
    int bad = 0;
    logic [127:0] exp;
    do begin
      tick();
      n++;
      if (done !== 1'b1 && busy !== 1'b1) bad++;
    end while (done !== 1'b1 && n < LAT + 4);
    check("done_latency", n, exp_edges);
    check("busy_held", bad, 0);
    check("busy_drop", busy, 1'b0);
    if (w) begin
      exp = exp_q.pop_front();
      check("rdata", rdata, exp);
      last_rd = exp;
    end else begin
      check("rdata_hold", rdata, last_rd);
    end
  endtask

  task automatic start_op(input logic w, input logic [ADDR_W-1:0] a, input logic [127:0] d,
                          input logic [3:0] m);
    csn = 1'b0; wen = w; addr = a; wdata = d;
`ifdef DMEM_WORD_MASK_EN
    wmask = m;
`endif
    tick();
    csn = 1'b1; wen = 1'b1;
    addr  = ADDR_W'($urandom);
    wdata = {$urandom, $urandom, $urandom, $urandom};
    check("accept_busy", busy, 1'b1);
    check("accept_done", done, 1'b0);
    check("accept_state", state, 1'b1);
    check("accept_count", count, LAT - 1);
    if (!w) model_write(int'(a), d, m);
    else exp_q.push_back(model_read(int'(a)));
  endtask

  task automatic do_op(input logic w, input logic [ADDR_W-1:0] a, input logic [127:0] d,
                       input logic [3:0] m);
    start_op(w, a, d, m);
    wait_done(w, LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d, d_old, d_new;
    logic [ADDR_W-1:0] a;
    logic w;

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rdata", rdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_collide", collide, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;
    tick();

    // write then read back on the DONE cycle
    do_op(1'b0, 10'h005, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 4'hF);
    do_op(1'b1, 10'h005, '0, 4'hF);
    check("rd_after_wr", rdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    tick();
    check("done_one_cycle", done, 1'b0);

    // LATENCY=1 instance, back-to-back on the DONE cycle
    d = {$urandom, $urandom, $urandom, $urandom};
    csn1 = 1'b0; wen1 = 1'b0; addr1 = 10'h003; wdata1 = d;
    tick();
    csn1 = 1'b1; wdata1 = ~d;
    check("l1_busy", busy1, 1'b1);
    check("l1_done_early", done1, 1'b0);
    tick();
    check("l1_done", done1, 1'b1);
    check("l1_busy_drop", busy1, 1'b0);
    csn1 = 1'b0; wen1 = 1'b1; addr1 = 10'h003;
    tick();
    csn1 = 1'b1;
    check("l1_b2b_busy", busy1, 1'b1);
    check("l1_b2b_done", done1, 1'b0);
    tick();
    check("l1_rd_done", done1, 1'b1);
    check("l1_rdata", rdata1, d);
    tick();
    check("l1_done_drop", done1, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, ADDR_W'(10'h040 + i), {$urandom, $urandom, $urandom, $urandom}, 4'hF);
    end
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(DEPTH, 1023));
      else a = ADDR_W'(10'h040 + $urandom_range(0, 7));
      do_op(~w, a, {$urandom, $urandom, $urandom, $urandom}, 4'hF);
      repeat ($urandom_range(0, 2)) tick();
    end
    check("no_false_collide", collide, 1'b0);

    // collision during a read
    d_old = {$urandom, $urandom, $urandom, $urandom};
    d_new = {$urandom, $urandom, $urandom, $urandom};
    do_op(1'b0, 10'h010, d_old, 4'hF);
    do_op(1'b0, 10'h011, d_new, 4'hF);
    start_op(1'b1, 10'h010, '0, 4'hF);
    tick();
    csn = 1'b0; wen = 1'b0; addr = 10'h011; wdata = ~d_new;
    tick();
    csn = 1'b1; wen = 1'b1;
    check("collide_set", collide, 1'b1);
    wait_done(1'b1, LAT - 2);
    check("collide_rd", rdata, d_old);
    do_op(1'b1, 10'h011, '0, 4'hF);
    check("collide_unchanged", rdata, d_new);
    check("collide_sticky", collide, 1'b1);

    // reset in the middle of a write
    d_old = {$urandom, $urandom, $urandom, $urandom};
    do_op(1'b0, 10'h020, d_old, 4'hF);
    csn = 1'b0; wen = 1'b0; addr = 10'h020; wdata = ~d_old;
    tick();
    csn = 1'b1; wen = 1'b1;
    tick();
    tick();
    #2;
    RSTn = 1'b0;
    #1;
    check("midrst_rdata", rdata, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_collide", collide, 1'b0);
    last_rd = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    do_op(1'b1, 10'h020, '0, 4'hF);
    check("midrst_old_data", rdata, d_old);

    // out-of-range read returns zero with normal timing
    do_op(1'b1, 10'h3FF, '0, 4'hF);
    check("oor_rdata", rdata, '0);

`ifdef DMEM_WORD_MASK_EN
    do_op(1'b0, 10'h007, {128{1'b1}}, 4'hF);
    do_op(1'b0, 10'h007, '0, 4'b0100);
    do_op(1'b0, 10'h007, '0, 4'b0000);
    do_op(1'b1, 10'h007, '0, 4'hF);
    check("mask_word2", rdata, 128'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
